// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the execute-stage comparator arbiter.
// Holds the FSM encoding, the default operand width and the requester indices.
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CMP  = 2'b01,
        RSP  = 2'b10
    } state_t;

    localparam int DEF_WIDTH = 16;

    localparam logic REQ_BR  = 1'b0;
    localparam logic REQ_ALU = 1'b1;

endpackage

// File: rtl/cmp_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to prio.
// Purely combinational; grant is one-hot and zero when nobody is valid.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        case (valid)
            2'b01: begin
                grant     = 2'b01;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant     = 2'b10;
                grant_idx = 1'b1;
            end
            2'b11: begin
                grant     = prio ? 2'b10 : 2'b01;
                grant_idx = prio;
            end
            default: begin
                grant     = 2'b00;
                grant_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Shares one external signed comparator between the branch unit and the ALU path.
// Latency: accept at edge T, response pulse during cycle T+2; one compare every 3 cycles.
// Backpressure: ready only in IDLE for the granted requester. CMP_ARB_EQ_EN adds eq outputs.
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter bit RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    output logic             req1_ready,
    output logic [WIDTH-1:0] cmp_A,
    output logic [WIDTH-1:0] cmp_B,
    input  logic             cmp_out,
    output logic             rsp0_valid,
    output logic             rsp0_gt,
    output logic             rsp1_valid,
    output logic             rsp1_gt,
`ifdef CMP_ARB_EQ_EN
    output logic             rsp0_eq,
    output logic             rsp1_eq,
`endif
    output logic             busy
);

    state_t     state;
    logic       prio;
    logic       owner;
    logic       result;
    logic [1:0] grant;
    logic       grant_idx;

    rr_pick2 u_pick (
        .valid     ({req1_valid, req0_valid}),
        .prio      (prio),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req0_ready = (state == IDLE) & grant[0];
    assign req1_ready = (state == IDLE) & grant[1];
    assign busy       = (state != IDLE);

    // The pulse flops gate the result so gt/eq read 0 outside the response cycle.
    assign rsp0_gt = rsp0_valid & result;
    assign rsp1_gt = rsp1_valid & result;

`ifdef CMP_ARB_EQ_EN
    logic eq_r;

    assign rsp0_eq = rsp0_valid & eq_r;
    assign rsp1_eq = rsp1_valid & eq_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            eq_r <= 1'b0;
        end else if (state == CMP) begin
            eq_r <= (cmp_A == cmp_B);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= RR_INIT;
            owner      <= 1'b0;
            result     <= 1'b0;
            cmp_A      <= '0;
            cmp_B      <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        cmp_A <= grant_idx ? req1_A : req0_A;
                        cmp_B <= grant_idx ? req1_B : req0_B;
                        owner <= grant_idx;
                        state <= CMP;
                    end
                end
                CMP: begin
                    result     <= cmp_out;
                    rsp0_valid <= (owner == REQ_BR);
                    rsp1_valid <= (owner == REQ_ALU);
                    state      <= RSP;
                end
                RSP: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    prio       <= ~owner;
                    state      <= IDLE;
                end
                default: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomized and directed bench for cmp_arbiter against a cycle-arithmetic model.
// The bench also plays the external comparator.
module tb_cmp_arbiter;

    localparam int W       = 16;
    localparam bit RR_INIT = 1'b0;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_A, req0_B, req1_A, req1_B;
    logic         req0_ready, req1_ready;
    logic [W-1:0] cmp_A, cmp_B;
    logic         cmp_out;
    logic         rsp0_valid, rsp0_gt, rsp1_valid, rsp1_gt;
`ifdef CMP_ARB_EQ_EN
    logic         rsp0_eq, rsp1_eq;
`endif
    logic         busy;

    always #5 clk = ~clk;

    assign cmp_out = $signed(cmp_A) > $signed(cmp_B);

    cmp_arbiter #(.WIDTH(W), .RR_INIT(RR_INIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_A     (req0_A),
        .req0_B     (req0_B),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_A     (req1_A),
        .req1_B     (req1_B),
        .req1_ready (req1_ready),
        .cmp_A      (cmp_A),
        .cmp_B      (cmp_B),
        .cmp_out    (cmp_out),
        .rsp0_valid (rsp0_valid),
        .rsp0_gt    (rsp0_gt),
        .rsp1_valid (rsp1_valid),
        .rsp1_gt    (rsp1_gt),
`ifdef CMP_ARB_EQ_EN
        .rsp0_eq    (rsp0_eq),
        .rsp1_eq    (rsp1_eq),
`endif
        .busy       (busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: each accept occupies the resource for 3 cycles, the answer appears 2 cycles later.
    int           cyc     = 0;
    int           acc_cyc = -1000;
    bit           chk_en  = 1'b0;
    bit           m_prio  = RR_INIT;
    bit           m_owner = 1'b0;
    logic [W-1:0] m_a     = '0;
    logic [W-1:0] m_b     = '0;
    bit           xfer0, xfer1;
    int           acc_own_q[$];
    int           acc_t_q[$];
    int           rsp_own_q[$];
    bit           rsp_gt_q[$];
    bit           rsp_eq_q[$];

    int age;
    bit g0, g1, rv0, rv1, egt, eeq;

    always @(negedge clk) begin
        xfer0 = 1'b0;
        xfer1 = 1'b0;
        if (chk_en) begin
            age = cyc - acc_cyc;
            if (req0_valid && req1_valid) begin
                g0 = (m_prio == 1'b0);
                g1 = !g0;
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
            g0  = g0 && (age >= 3);
            g1  = g1 && (age >= 3);
            rv0 = (age == 2) && (m_owner == 1'b0);
            rv1 = (age == 2) && (m_owner == 1'b1);
            egt = $signed(m_a) > $signed(m_b);
            eeq = (m_a == m_b);
            check("req0_ready", req0_ready, g0);
            check("req1_ready", req1_ready, g1);
            check("busy", busy, (age == 1) || (age == 2));
            check("cmp_A", cmp_A, m_a);
            check("cmp_B", cmp_B, m_b);
            check("rsp0_valid", rsp0_valid, rv0);
            check("rsp0_gt", rsp0_gt, rv0 && egt);
            check("rsp1_valid", rsp1_valid, rv1);
            check("rsp1_gt", rsp1_gt, rv1 && egt);
`ifdef CMP_ARB_EQ_EN
            check("rsp0_eq", rsp0_eq, rv0 && eeq);
            check("rsp1_eq", rsp1_eq, rv1 && eeq);
`endif
            if (rsp0_valid || rsp1_valid) begin
                rsp_own_q.push_back(rsp1_valid ? 1 : 0);
                rsp_gt_q.push_back(rsp0_gt | rsp1_gt);
`ifdef CMP_ARB_EQ_EN
                rsp_eq_q.push_back(rsp0_eq | rsp1_eq);
`else
                rsp_eq_q.push_back(1'b0);
`endif
            end
            if (rst) begin
                acc_cyc = -1000;
                m_prio  = RR_INIT;
                m_owner = 1'b0;
                m_a     = '0;
                m_b     = '0;
            end else if (g0 || g1) begin
                acc_cyc = cyc;
                m_owner = g1;
                m_a     = g1 ? req1_A : req0_A;
                m_b     = g1 ? req1_B : req0_B;
                m_prio  = !g1;
                xfer0   = g0;
                xfer1   = g1;
                acc_own_q.push_back(g1 ? 1 : 0);
                acc_t_q.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic drive(input int idx, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        if (idx == 0) begin
            req0_valid = v; req0_A = a; req0_B = b;
        end else begin
            req1_valid = v; req1_A = a; req1_B = b;
        end
    endtask

    // Returns #1 after the accepting edge, i.e. inside the CMP cycle.
    task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        bit done = 1'b0;
        @(posedge clk); #1;
        drive(idx, 1'b1, a, b);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((idx == 0) ? req0_ready : req1_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("issue_timeout", 0, 1);
        @(posedge clk); #1;
        drive(idx, 1'b0, a, b);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_own_q.delete(); acc_t_q.delete();
        rsp_own_q.delete(); rsp_gt_q.delete(); rsp_eq_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [W-1:0] sa, sb;
    bit           done_flag;

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        settle();

        // Lone requester 0, extreme signed operands.
        clear_logs();
        issue(0, 16'h7FFF, 16'h8000);
        settle();
        check("t1_rsp_cnt", rsp_own_q.size(), 1);
        check("t1_owner", rsp_own_q[0], 0);
        check("t1_gt", rsp_gt_q[0], 1);

        // Lone requester 1: less-than, then equal.
        clear_logs();
        issue(1, 16'h8000, 16'h7FFF);
        settle();
        issue(1, 16'h1234, 16'h1234);
        settle();
        check("t2_rsp_cnt", rsp_own_q.size(), 2);
        check("t2_owner", rsp_own_q[0], 1);
        check("t2_gt_lt", rsp_gt_q[0], 0);
        check("t2_gt_eq", rsp_gt_q[1], 0);
`ifdef CMP_ARB_EQ_EN
        check("t2_eq_lt", rsp_eq_q[0], 0);
        check("t2_eq_eq", rsp_eq_q[1], 1);
`endif

        // Both held valid after reset: strict alternation, 3-cycle spacing.
        do_reset();
        clear_logs();
        drive(0, 1'b1, W'($urandom), W'($urandom));
        drive(1, 1'b1, W'($urandom), W'($urandom));
        for (int k = 0; k < 40 && acc_own_q.size() < 4; k++) begin
            @(posedge clk); #1;
            if (xfer0) drive(0, 1'b1, W'($urandom), W'($urandom));
            if (xfer1) drive(1, 1'b1, W'($urandom), W'($urandom));
        end
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        settle();
        check("rr_acc_cnt", acc_own_q.size(), 4);
        for (int i = 0; i < 4; i++) check("rr_order", acc_own_q[i], i % 2);
        for (int i = 1; i < 4; i++) check("rr_spacing", acc_t_q[i] - acc_t_q[i-1], 3);
        check("rr_rsp_cnt", rsp_own_q.size(), 4);
        check("rr_rsp_owner", rsp_own_q[1], 1);

        // Sweep A down from 7FFF and B up from 8000 until A reaches 8000.
        clear_logs();
        sa = 16'h7FFF;
        sb = 16'h8000;
        for (int k = 0; k < 256; k++) begin
            issue(0, sa, sb);
            sa = sa - 16'h0101;
            sb = sb + 16'h0101;
        end
        settle();
        check("sweep_rsp_cnt", rsp_own_q.size(), 256);
        check("sweep_first_gt", rsp_gt_q[0], 1);
        check("sweep_last_gt", rsp_gt_q[255], 0);

        // Reset during CMP discards the answer and restores priority to RR_INIT.
        issue(0, 16'h0005, 16'h0003);
        settle();
        clear_logs();
        issue(0, 16'h0009, 16'h0001);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        settle();
        check("rst_no_rsp", rsp_own_q.size(), 0);
        clear_logs();
        drive(0, 1'b1, 16'h0100, 16'h0200);
        drive(1, 1'b1, 16'h0300, 16'h0050);
        done_flag = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (xfer0 || xfer1) begin
                done_flag = 1'b1;
                break;
            end
        end
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        check("rst_grant_seen", done_flag, 1);
        check("rst_grant_owner", acc_own_q[0], RR_INIT);
        settle();

        // A one-cycle valid pulse while busy must not transfer.
        clear_logs();
        issue(1, 16'h0042, 16'h0041);
        drive(0, 1'b1, 16'h7000, 16'h0001);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, '0);
        settle();
        check("pulse_acc_cnt", acc_own_q.size(), 1);
        check("pulse_rsp_cnt", rsp_own_q.size(), 1);
        check("pulse_rsp_owner", rsp_own_q[0], 1);

        // Random traffic, requesters obey hold-until-ready but may withdraw.
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            if (xfer0) begin
                if ($urandom_range(1) == 0) req0_valid = 1'b0;
                else begin
                    sa = W'($urandom);
                    sb = ($urandom_range(3) == 0) ? sa : W'($urandom);
                    drive(0, 1'b1, sa, sb);
                end
            end else if (req0_valid) begin
                if ($urandom_range(15) == 0) req0_valid = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                sa = W'($urandom);
                sb = ($urandom_range(3) == 0) ? sa : W'($urandom);
                drive(0, 1'b1, sa, sb);
            end
            if (xfer1) begin
                if ($urandom_range(1) == 0) req1_valid = 1'b0;
                else begin
                    sa = W'($urandom);
                    sb = ($urandom_range(3) == 0) ? sa : W'($urandom);
                    drive(1, 1'b1, sa, sb);
                end
            end else if (req1_valid) begin
                if ($urandom_range(15) == 0) req1_valid = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                sa = W'($urandom);
                sb = ($urandom_range(3) == 0) ? sa : W'($urandom);
                drive(1, 1'b1, sa, sb);
            end
        end
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
